// File: rtl/activation_streamer_pkg.sv
// Shared types for the activation streamer: FSM states, stage-1 sideband and padded-size width.
package activation_streamer_pkg;

    // Width of the padded size P and of the row/column counters
    localparam int PW = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic is_pad;
        logic last;
    } stage_t;

endpackage

// File: rtl/pad_position_counter.sv
// Raster row/column counter over a P x P padded frame with interior/last/wrap flags.
module pad_position_counter
    import activation_streamer_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [PW-1:0] p_i,
    input  logic [PW-1:0] lo_i,
    input  logic [PW-1:0] hi_i,
    output logic          interior_o,
    output logic          last_o,
    output logic          wrap_o
);

    logic [PW-1:0] row_p0;
    logic [PW-1:0] col_p0;

    // Position flags are derived from the current (r, c) being issued
    always_comb begin
        wrap_o     = (col_p0 == p_i - PW'(1));
        last_o     = wrap_o && (row_p0 == p_i - PW'(1));
        interior_o = (row_p0 >= lo_i) && (row_p0 < hi_i) &&
                     (col_p0 >= lo_i) && (col_p0 < hi_i);
    end

    // Advance one position per enabled cycle, column fastest
    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) begin
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (en_i) begin
            if (wrap_o) begin
                col_p0 <= '0;
                row_p0 <= row_p0 + PW'(1);
            end else begin
                col_p0 <= col_p0 + PW'(1);
            end
        end
    end

endmodule

// File: rtl/activation_streamer.sv
// Streams a zero-padded S x S activation matrix from a 1-cycle-latency memory in raster order.
module activation_streamer
    import activation_streamer_pkg::*;
#(
    parameter int N             = 16,
    parameter int MaxMatrixSize = 16383,
    parameter int PadWidth      = 4,
    parameter int AddrWidth     = 28
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [13:0]          matrix_size_i,
    input  logic [PadWidth-1:0]  padding_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic                 stall_i,
    output logic                 mem_rd_en_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic signed [N-1:0]  mem_data_i,
    output logic signed [N-1:0]  data_o,
    output logic                 valid_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic [PW-1:0]        padded_size_o
);

    state_t                state_p0;
    logic [13:0]           size_q;
    logic [PadWidth-1:0]   pad_q;
    logic [PW-1:0]         p_q;
    logic [AddrWidth-1:0]  rd_ptr_p0;
    logic                  interior_p0;
    logic                  last_p0;
    logic                  wrap_p0;
    logic                  issue_p0;
    logic                  start_ok;
    logic [PW-1:0]         lo_p0;
    logic [PW-1:0]         hi_p0;
    stage_t                stage_p1;
    logic signed [N-1:0]   data_p2;
    logic                  vld_p2;
    logic                  done_p2;

    assign start_ok    = start_i && (matrix_size_i != '0) &&
                         (int'(matrix_size_i) <= MaxMatrixSize);
    assign issue_p0    = (state_p0 == RUN) && !stall_i;
    assign lo_p0       = PW'(pad_q);
    assign hi_p0       = PW'(pad_q) + PW'(size_q);
    assign mem_rd_en_o = issue_p0 && interior_p0;
    assign mem_addr_o  = rd_ptr_p0;

    pad_position_counter u_pos (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    ((state_p0 == IDLE) && start_ok),
        .en_i       (issue_p0),
        .p_i        (p_q),
        .lo_i       (lo_p0),
        .hi_i       (hi_p0),
        .interior_o (interior_p0),
        .last_o     (last_p0),
        .wrap_o     (wrap_p0)
    );

    // Stage 0: frame control FSM, configuration latch and contiguous read pointer
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_p0  <= IDLE;
            size_q    <= '0;
            pad_q     <= '0;
            p_q       <= '0;
            rd_ptr_p0 <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (start_ok) begin
                        size_q    <= matrix_size_i;
                        pad_q     <= padding_i;
                        p_q       <= PW'(matrix_size_i) + (PW'(padding_i) << 1);
                        rd_ptr_p0 <= base_addr_i;
                        state_p0  <= RUN;
                    end
                end
                RUN: begin
                    if (issue_p0 && interior_p0) rd_ptr_p0 <= rd_ptr_p0 + AddrWidth'(1);
                    if (issue_p0 && last_p0) state_p0 <= DRAIN;
                end
                DRAIN: begin
                    if (done_p2) state_p0 <= IDLE;
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end

    // Stage 1: sideband travels with the outstanding read; frozen while stalled
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stage_p1 <= '0;
        end else if (!stall_i) begin
            stage_p1 <= '{valid: issue_p0, is_pad: !interior_p0, last: last_p0};
        end
    end

    // Stage 2: output register; a stall bubbles valid/done and holds data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_p2  <= 1'b0;
            done_p2 <= 1'b0;
            data_p2 <= '0;
        end else if (stall_i) begin
            vld_p2  <= 1'b0;
            done_p2 <= 1'b0;
        end else begin
            vld_p2  <= stage_p1.valid;
            done_p2 <= stage_p1.valid && stage_p1.last;
            data_p2 <= stage_p1.is_pad ? '0 : mem_data_i;
        end
    end

    assign data_o        = data_p2;
    assign valid_o       = vld_p2;
    assign done_o        = done_p2;
    assign busy_o        = (state_p0 != IDLE);
    assign padded_size_o = p_q;

endmodule

// File: tb/tb_activation_streamer.sv
// Self-checking bench for activation_streamer: directed frames plus randomized frames vs a raster model.
module tb_activation_streamer;

    localparam int N  = 16;
    localparam int AW = 28;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [13:0]          matrix_size_i;
    logic [3:0]           padding_i;
    logic [AW-1:0]        base_addr_i;
    logic                 stall_i;
    logic                 mem_rd_en_o;
    logic [AW-1:0]        mem_addr_o;
    logic signed [N-1:0]  mem_data_i;
    logic signed [N-1:0]  data_o;
    logic                 valid_o;
    logic                 done_o;
    logic                 busy_o;
    logic [14:0]          padded_size_o;

    always #5 clk = ~clk;

    activation_streamer dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .matrix_size_i (matrix_size_i),
        .padding_i     (padding_i),
        .base_addr_i   (base_addr_i),
        .stall_i       (stall_i),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .padded_size_o (padded_size_o)
    );

    // Memory model: 1-cycle read latency, output holds while not reading
    logic signed [N-1:0] tbmem [0:1023];
    always @(posedge clk) if (mem_rd_en_o) mem_data_i <= tbmem[mem_addr_o[9:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge
    logic signed [N-1:0] obs_data[$];
    int                  obs_cyc[$];
    logic [AW-1:0]       obs_addr[$];
    int                  done_cnt = 0;
    logic signed [N-1:0] done_val;
    int                  done_cyc;
    logic                done_v;
    always @(negedge clk) begin
        if (valid_o) begin
            obs_data.push_back(data_o);
            obs_cyc.push_back(cyc);
        end
        if (mem_rd_en_o) obs_addr.push_back(mem_addr_o);
        if (done_o) begin
            done_cnt++;
            done_val = data_o;
            done_cyc = cyc;
            done_v   = valid_o;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: padded raster of the matrix stored row-major at base
    logic signed [N-1:0] exp_q[$];
    task automatic build_expected(input int s, input int pad, input int base);
        int p;
        p = s + 2 * pad;
        exp_q.delete();
        for (int r = 0; r < p; r++)
            for (int c = 0; c < p; c++)
                if (r >= pad && r < pad + s && c >= pad && c < pad + s)
                    exp_q.push_back(tbmem[base + (r - pad) * s + (c - pad)]);
                else
                    exp_q.push_back('0);
    endtask

    // mode: 0 none, 1 random stalls, 2 two-cycle stall after 4th valid, 3 stray start mid-frame
    task automatic run_frame(input int s, input int pad, input int base, input int mode, input bit chk_lat);
        int p, v0, a0, d0, c0, nv, na, stall_left;
        bit stalled_once;
        p = s + 2 * pad;
        v0 = obs_data.size();
        a0 = obs_addr.size();
        d0 = done_cnt;
        stall_left = 0;
        stalled_once = 0;
        build_expected(s, pad, base);
        @(posedge clk); #1;
        matrix_size_i = 14'(s);
        padding_i     = 4'(pad);
        base_addr_i   = AW'(base);
        start_i       = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(1));
        chk("padded_size", 64'(padded_size_o), 64'(p));
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != d0) break;
            case (mode)
                1: stall_i = ($urandom_range(0, 3) == 0);
                2: begin
                    if (!stalled_once && obs_data.size() - v0 >= 4) begin
                        stalled_once = 1'b1;
                        stall_left = 2;
                    end
                    stall_i = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
                3: begin
                    start_i = (i == 3);
                    matrix_size_i = 14'd5;
                end
                default: stall_i = 1'b0;
            endcase
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        chk("done_count", 64'(done_cnt - d0), 64'(1));
        chk("busy_after_done", 64'(busy_o), 64'(0));
        nv = obs_data.size() - v0;
        na = obs_addr.size() - a0;
        chk("valid_count", 64'(nv), 64'(p * p));
        for (int k = 0; k < nv && k < p * p; k++)
            chk("data", 64'(obs_data[v0 + k]), 64'(exp_q[k]));
        chk("read_count", 64'(na), 64'(s * s));
        for (int k = 0; k < na && k < s * s; k++)
            chk("read_addr", 64'(obs_addr[a0 + k]), 64'(base + k));
        if (nv > 0) begin
            chk("done_value", 64'(done_val), 64'(exp_q[p * p - 1]));
            chk("done_with_valid", 64'(done_v), 64'(1));
            chk("done_on_last", 64'(done_cyc), 64'(obs_cyc[v0 + nv - 1]));
            if (chk_lat)
                chk("first_latency", 64'(obs_cyc[v0] - c0), 64'(3));
            if (mode == 0 || mode == 3)
                chk("span_unstalled", 64'(obs_cyc[v0 + nv - 1] - obs_cyc[v0]), 64'(p * p - 1));
            if (mode == 2)
                chk("span_stalled", 64'(obs_cyc[v0 + nv - 1] - obs_cyc[v0]), 64'(p * p + 1));
        end
    endtask

    initial begin
        int v0, a0, d0, s, pad, base;
        rst_i = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        matrix_size_i = '0;
        padding_i = '0;
        base_addr_i = '0;
        for (int i = 0; i < 1024; i++) tbmem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_rd_en", 64'(mem_rd_en_o), 64'(0));
        chk("rst_data", 64'(data_o), 64'(0));
        chk("rst_psize", 64'(padded_size_o), 64'(0));
        @(posedge clk); #1;
        rst_i = 1'b1;

        // 3x3, no padding
        for (int i = 0; i < 9; i++) tbmem[i] = N'(i + 1);
        run_frame(3, 0, 0, 0, 1'b1);

        // 2x2 with one ring of padding
        for (int i = 0; i < 4; i++) tbmem[i] = N'(i + 1);
        run_frame(2, 1, 0, 0, 1'b1);

        // Two-cycle stall mid-frame
        for (int i = 0; i < 9; i++) tbmem[i] = N'(i + 1);
        run_frame(3, 0, 0, 2, 1'b1);

        // Single negative element inside a 5x5 padded frame
        tbmem[100] = -16'sd5;
        v0 = obs_data.size();
        run_frame(1, 2, 100, 0, 1'b1);
        if (obs_data.size() - v0 > 12)
            chk("centre_neg5", 64'(obs_data[v0 + 12]), -64'sd5);

        // Stray start while busy is ignored
        for (int i = 0; i < 9; i++) tbmem[i] = N'(i + 1);
        run_frame(3, 0, 0, 3, 1'b1);

        // Reset in the middle of a frame
        d0 = done_cnt;
        @(posedge clk); #1;
        matrix_size_i = 14'd4;
        padding_i = 4'd1;
        base_addr_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_done", 64'(done_o), 64'(0));
        chk("midrst_rd_en", 64'(mem_rd_en_o), 64'(0));
        @(posedge clk); #1;
        rst_i = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
        run_frame(3, 0, 0, 0, 1'b1);

        // Start with S = 0 is ignored
        v0 = obs_data.size();
        a0 = obs_addr.size();
        d0 = done_cnt;
        @(posedge clk); #1;
        matrix_size_i = '0;
        padding_i = 4'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (6) begin
            chk("s0_busy", 64'(busy_o), 64'(0));
            @(posedge clk); #1;
        end
        chk("s0_valids", 64'(obs_data.size() - v0), 64'(0));
        chk("s0_reads", 64'(obs_addr.size() - a0), 64'(0));
        chk("s0_done", 64'(done_cnt - d0), 64'(0));

        // Randomized frames, alternating clean and randomly stalled
        for (int f = 0; f < 8; f++) begin
            s = $urandom_range(1, 5);
            pad = $urandom_range(0, 3);
            base = $urandom_range(0, 900);
            for (int k = 0; k < s * s; k++) tbmem[base + k] = N'($urandom);
            run_frame(s, pad, base, f % 2, (f % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
